// File: rtl/inst_sram_axi_bridge.sv
// Read-only bridge from the IF stage's SRAM-like instruction port to an AXI read channel.
// Each accepted fetch becomes one single-beat AR transaction; data returns in order.
module inst_sram_axi_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    // SRAM-like instruction port
    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_err,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StIdle, StArWait} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     araddr_q;
    logic [1:0]      size_q;
    logic            arvalid_q;
    logic            data_ok_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic accept;
    logic r_hs;
    logic r_take;
    logic unused_r;

    // Single ARID and single-beat bursts: rid/rlast carry no extra information.
    assign unused_r = ^{rid, rlast};

    assign rready = ~reset;
    assign r_hs   = rvalid & rready;
    // A beat arriving with nothing outstanding is a protocol error and is dropped.
    assign r_take = r_hs & (cnt_q != '0);
    // Slot check uses the registered count only; a same-cycle return frees nothing yet.
    assign accept = ~reset & (state_q == StIdle) & inst_sram_req & (cnt_q < MaxCnt);

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign inst_sram_err     = err_q;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            araddr_q  <= '0;
            size_q    <= '0;
            arvalid_q <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        araddr_q  <= inst_sram_addr;
                        size_q    <= inst_sram_size;
                        arvalid_q <= 1'b1;
                        state_q   <= StArWait;
                    end
                end
                StArWait: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase

            data_ok_q <= r_take;
            if (r_take) begin
                rdata_q <= rdata;
                err_q   <= rresp[1];
            end

            if (accept && !r_take) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!accept && r_take) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: fetch, AR stall, outstanding limit,
// simultaneous accept/return, error response, drop on empty, async reset mid-operation.
module tb_inst_sram_axi_bridge;
    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_chk;
    int n_fail;

    inst_sram_axi_bridge #(
        .MAX_OUTSTANDING(2),
        .ARID_VAL       (4'd0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .inst_sram_err    (inst_sram_err),
        .arid             (arid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arvalid          (arvalid),
        .arready          (arready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .rvalid           (rvalid),
        .rready           (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        inst_sram_req  = 1'b1;
        inst_sram_size = 2'd2;
        inst_sram_addr = 32'h1c00_0000;
        arready        = 1'b0;
        rid            = 4'd0;
        rdata          = 32'h0;
        rresp          = 2'b00;
        rlast          = 1'b1;
        rvalid         = 1'b0;

        // Reset state, with req already high
        next_cycle();
        next_cycle();
        check("rst_addr_ok", inst_sram_addr_ok, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_data_ok", inst_sram_data_ok, 0);
        check("rst_rdata", inst_sram_rdata, 0);
        check("rst_err", inst_sram_err, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_cnt", dut.cnt_q, 0);

        // 1: single fetch
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t1_addr_ok", inst_sram_addr_ok, 1);
        check("t1_rready", rready, 1);
        check("t1_arlen", arlen, 0);
        check("t1_arburst", arburst, 1);
        check("t1_arid", arid, 0);
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        #1;
        check("t1_arvalid", arvalid, 1);
        check("t1_araddr", araddr, 32'h1c00_0000);
        check("t1_arsize", arsize, 2);
        check("t1_cnt", dut.cnt_q, 1);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0280_0000;
        #1;
        check("t1_arvalid_clr", arvalid, 0);
        check("t1_no_early_data_ok", inst_sram_data_ok, 0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("t1_data_ok", inst_sram_data_ok, 1);
        check("t1_rdata", inst_sram_rdata, 32'h0280_0000);
        check("t1_err", inst_sram_err, 0);
        check("t1_cnt_done", dut.cnt_q, 0);
        next_cycle();
        check("t1_data_ok_pulse", inst_sram_data_ok, 0);
        check("t1_rdata_hold", inst_sram_rdata, 32'h0280_0000);

        // 2: AR stall with req dropping
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0004;
        #1;
        check("t2_addr_ok", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_req  = 1'b0;
        inst_sram_addr = 32'hffff_fff0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_stall_arvalid", arvalid, 1);
            check("t2_stall_araddr", araddr, 32'h1c00_0004);
            check("t2_stall_addr_ok", inst_sram_addr_ok, 0);
            check("t2_stall_cnt", dut.cnt_q, 1);
            @(negedge clk);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        check("t2_arvalid_clr", arvalid, 0);

        // 3: outstanding limit (cnt=1 -> second accept, third blocked)
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0008;
        #1;
        check("t3_second_accept", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_addr = 32'h1c00_000c;
        arready        = 1'b1;
        #1;
        check("t3_wait_addr_ok", inst_sram_addr_ok, 0);
        @(negedge clk);
        arready = 1'b0;
        #1;
        check("t3_cnt_full", dut.cnt_q, 2);
        check("t3_full_addr_ok", inst_sram_addr_ok, 0);
        @(negedge clk);
        #1;
        check("t3_still_blocked", inst_sram_addr_ok, 0);
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'h1111_1111;
        #1;
        check("t3_same_cycle_blocked", inst_sram_addr_ok, 0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("t3_data_ok", inst_sram_data_ok, 1);
        check("t3_rdata", inst_sram_rdata, 32'h1111_1111);
        check("t3_cnt_freed", dut.cnt_q, 1);
        check("t3_third_accept", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        #1;
        check("t3_araddr", araddr, 32'h1c00_000c);
        check("t3_cnt2", dut.cnt_q, 2);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h2222_2222;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("t3_drain_rdata", inst_sram_rdata, 32'h2222_2222);
        check("t3_drain_cnt", dut.cnt_q, 1);

        // 4: accept and R handshake in the same cycle, cnt=1
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0010;
        rvalid         = 1'b1;
        rdata          = 32'h3333_3333;
        #1;
        check("t4_addr_ok", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        rvalid        = 1'b0;
        arready       = 1'b1;
        #1;
        check("t4_cnt_same", dut.cnt_q, 1);
        check("t4_data_ok", inst_sram_data_ok, 1);
        check("t4_rdata", inst_sram_rdata, 32'h3333_3333);
        check("t4_araddr", araddr, 32'h1c00_0010);
        @(negedge clk);
        arready = 1'b0;

        // 5: error response then OKAY
        rvalid = 1'b1;
        rresp  = 2'b10;
        rdata  = 32'hdead_beef;
        @(negedge clk);
        rvalid = 1'b0;
        rresp  = 2'b00;
        #1;
        check("t5_err_data_ok", inst_sram_data_ok, 1);
        check("t5_err", inst_sram_err, 1);
        check("t5_err_cnt", dut.cnt_q, 0);
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0014;
        #1;
        check("t5_err_hold", inst_sram_err, 1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("t5_ok_data_ok", inst_sram_data_ok, 1);
        check("t5_ok_err", inst_sram_err, 0);
        check("t5_ok_rdata", inst_sram_rdata, 32'h1234_5678);

        // Stray beat with nothing outstanding is dropped
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'h5555_5555;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("drop_data_ok", inst_sram_data_ok, 0);
        check("drop_cnt", dut.cnt_q, 0);
        check("drop_rdata", inst_sram_rdata, 32'h1234_5678);

        // 6: reset asserted in AR_WAIT with cnt=2
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0020;
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        @(negedge clk);
        arready        = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0024;
        #1;
        check("t6_accept2", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        #1;
        check("t6_pre_arvalid", arvalid, 1);
        check("t6_pre_cnt", dut.cnt_q, 2);
        reset = 1'b1;
        #1;
        check("t6_arvalid", arvalid, 0);
        check("t6_data_ok", inst_sram_data_ok, 0);
        check("t6_cnt", dut.cnt_q, 0);
        check("t6_rready", rready, 0);
        check("t6_araddr", araddr, 0);
        @(negedge clk);
        reset          = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0100;
        #1;
        check("t6_post_addr_ok", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        #1;
        check("t6_post_arvalid", arvalid, 1);
        check("t6_post_araddr", araddr, 32'h1c00_0100);
        check("t6_post_cnt", dut.cnt_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
